uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver: 8N1 frames (optional parity) on a single line are recovered into parallel bytes. It is the receive-side counterpart of the board's transmit path and shares its baud constant, 5208 system clocks per bit (9600 baud at 50 MHz). It sits between the external RX pin and the command/data consumer logic. It presents each byte with a one-cycle valid strobe plus error flags.

## Interface
- `CLKS_PER_BIT`, 5208: system clocks per serial bit; must be an even integer ≥ 8.
- `DATA_BITS`, 8: payload bits per frame, LSB first; legal range 5–8.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_l`  in  1: reset, asynchronous assert, active-low. One clock, `clk`; no other clock domain exists inside the block.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  DATA_BITS: last received byte; holds until the next good frame.
- `rx_valid`  out  1: one-cycle strobe, `rx_data` is new.
- `frame_err`  out  1: one-cycle strobe, stop bit sampled low.
- `parity_err`  out  1: one-cycle strobe. Present only with `UART_RX_PARITY_EN`; otherwise tied 0.
- `busy`  out  1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the synchronizer flops reset to 1. All decisions use the synchronized signal `rx_s`.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: bit counter = 0 and tick counter = 0. When `rx_s` = 0, go to START.
- START: tick counter runs from 0. At tick = CLKS_PER_BIT/2−1, sample `rx_s`.
  - If the sample is 1, treat it as a glitch: return to IDLE with no strobe.
  - If the sample is 0, clear the tick counter and go to DATA.
- DATA: sample `rx_s` at tick = CLKS_PER_BIT−1, then clear the tick counter.
  - Shift the sample into the MSB of the shift register (LSB-first line order).
  - After DATA_BITS samples, go to PARITY (macro) or STOP.
- PARITY: sample at tick = CLKS_PER_BIT−1. The error condition is (XOR of data bits) ≠ the sample, i.e. even parity.
- STOP: sample at tick = CLKS_PER_BIT−1.
  - Sample 1: load `rx_data` from the shift register, pulse `rx_valid`, and pulse `parity_err` if the error condition holds. Go to IDLE.
  - Sample 0: pulse `frame_err`, do not update `rx_data`, do not pulse `rx_valid`. Go to BREAK.
- BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- With a parity error, `rx_valid` still pulses; the consumer decides what to do with the byte.
- Tick counter width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_BITS+1). Neither counter ever wraps past its terminal value.
- Reset asserted mid-frame: all state is discarded immediately. After release the FSM is in IDLE. A line that is still low in the middle of the frame is seen as a new start edge; this is accepted behaviour.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0. FSM is in IDLE.
- Let edge E be the first `clk` edge that samples `rx` low. START is entered at E+2, after the synchronizer.
- Without parity, the strobes register at E+2+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. They are visible for exactly one cycle.
- Parity adds CLKS_PER_BIT to that latency.
- `rx_data` changes on the same edge that `rx_valid` rises.
- `busy` falls on the same edge as the strobe.
- Back-to-back frames are supported. A start bit that begins right after the stop bit's midpoint is caught, because IDLE is re-entered half a bit early.
- There is no backpressure. If the consumer misses a strobe, that byte is lost.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state, the `parity_err` logic and 9-bit-plus frames (start, data, parity, stop) are compiled in.
- `UART_RX_PARITY_EN` undefined: PARITY is never entered and `parity_err` is constant 0. The frame is start, DATA_BITS, stop.

## Structure
- Shared package `uart_pkg` holds:
  - `CLKS_PER_BIT_DEFAULT` = 5208, shared with the transmitter and the divider.
  - The `uart_rx_state_t` enum.
  - `UART_DATA_BITS` = 8.
- Sub-module `sync_2ff` is the reusable 2-flop synchronizer; its reset value is a parameter, here 1.
- The FSM, counters and shift register stay in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Send byte 0x55, 8N1 → one `rx_valid` pulse with `rx_data` = 0x55, at exactly E+2+8+144 cycles; no error strobe.
- Send 0xA3 then 0x0F back-to-back with no idle gap → two `rx_valid` pulses carrying 0xA3 then 0x0F, 160 cycles apart.
- Drive `rx` low for 5 cycles, then high → no strobe of any kind; `busy` returns to 0 at E+2+8.
- Send 0x7E with the stop bit low, and hold the line low for 40 more cycles → `frame_err` pulses once; `rx_data` keeps its previous value; there is no further activity until the line goes high.
- Assert `rst_l` low during bit 4 of 0x99, release it with the line high → all outputs 0 and `busy` = 0. A following 0x3C is received correctly.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 0 → `rx_valid` and `parity_err` pulse together and `rx_data` = 0x01. With parity bit 1 → only `rx_valid` pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by uart_rx; parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RST_VAL so an idle line reads correctly out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_l,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS LSB first, optional even parity, stop.
// Define UART_RX_PARITY_EN to compile in the parity bit and parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'(RX_IDLE);
    localparam logic [2:0] S_START  = 3'(RX_START);
    localparam logic [2:0] S_DATA   = 3'(RX_DATA);
    localparam logic [2:0] S_STOP   = 3'(RX_STOP);
    localparam logic [2:0] S_BREAK  = 3'(RX_BREAK);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(RX_PARITY);
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bits;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_perr;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    r_bits <= '0;
                    if (!w_rx_s) r_state <= S_START;
                end
                // A high mid-start sample is a glitch, not a frame
                S_START: begin
                    if (r_tick == TICK_HALF) begin
                        r_tick  <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_tick == TICK_FULL) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bits  <= r_bits + BW'(1);
                        if (r_bits == LAST_BIT) r_state <= S_AFTER_DATA;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_tick == TICK_FULL) begin
                        r_tick    <= '0;
                        r_par_bad <= (^r_shift) != w_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_tick == TICK_FULL) begin
                        r_tick <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= r_par_bad;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                // Hold off until the line recovers so a stuck-low line cannot retrigger
                S_BREAK: begin
                    r_tick <= '0;
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule
